// File: rtl/imem_loader.sv
// imem_loader
//   Instruction-memory responder for the single-cycle RV32I core. The word
//   array is filled from a little-endian byte stream. The core is held in reset
//   while the stream loads, and is released once the last byte is accepted.
//
// Ports
//   clk           single clock, rising edge
//   reset         synchronous, active-high
//   imem_addr     byte fetch address from the core (bits [1:0] ignored)
//   imem_data     fetched word; combinational, NOP when unloaded/out of range
//   ld_valid      load byte present
//   ld_ready      block accepts a byte (high in LOAD only)
//   ld_data       load byte
//   ld_last       marks the final byte of the stream (sampled on accept)
//   core_reset    drives the core's reset; high until the load completes
//   load_done     high in RUN
//   load_err      sticky: a byte arrived after the array was full
//   words_loaded  number of words written, 0..DEPTH
module imem_loader #(
  parameter int          XLEN  = 32,
  parameter int          DEPTH = 256,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [XLEN-1:0]          imem_addr,
  output logic [31:0]              imem_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [7:0]               ld_data,
  input  logic                     ld_last,
  output logic                     core_reset,
  output logic                     load_done,
  output logic                     load_err,
  output logic [$clog2(DEPTH):0]   words_loaded
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] WORDS_MAX = (AW+1)'(DEPTH);

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_t;

  state_t        state, state_next;
  logic [1:0]    bidx;
  logic [23:0]   asm;
  logic [AW:0]   widx;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          full;
  logic          word_end;
  logic          do_write;
  logic [31:0]   wdata;

  // State register.
  // NOTE: sequential state is always assigned with <=, so every flop samples
  // the pre-edge values of its neighbours regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode. ld_ready is a pure decode of the state
  // register, so it never depends on ld_valid.
  // NOTE: every signal written here gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    core_reset = 1'b0;
    load_done  = 1'b0;
    unique case (state)
      S_LOAD: begin
        ld_ready   = 1'b1;
        core_reset = 1'b1;
        // ld_last ends the load even when the byte itself overflowed.
        if (ld_valid && ld_last) state_next = S_RUN;
      end
      S_RUN: begin
        load_done = 1'b1;
      end
      default: state_next = S_LOAD;
    endcase
  end

  assign accept   = ld_valid && ld_ready;
  assign full     = (widx == WORDS_MAX);
  assign word_end = (bidx == 2'd3) || ld_last;
  assign do_write = accept && !full && word_end && !reset;

  // Final word: incoming byte at lane bidx, assembled bytes below, zero above.
  always_comb begin
    unique case (bidx)
      2'd0:    wdata = {24'h0, ld_data};
      2'd1:    wdata = {16'h0, ld_data, asm[7:0]};
      2'd2:    wdata = {8'h0,  ld_data, asm[15:0]};
      default: wdata = {ld_data, asm};
    endcase
  end

  // Byte assembly, word counter and overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      bidx     <= 2'd0;
      asm      <= 24'h0;
      widx     <= '0;
      load_err <= 1'b0;
    end else if (accept) begin
      if (full) begin
        // Dropped byte: counters hold, only the sticky flag moves.
        load_err <= 1'b1;
      end else if (word_end) begin
        widx <= widx + 1'b1;
        bidx <= 2'd0;
        asm  <= 24'h0;
      end else begin
        unique case (bidx)
          2'd0:    asm[7:0]   <= ld_data;
          2'd1:    asm[15:8]  <= ld_data;
          default: asm[23:16] <= ld_data;
        endcase
        bidx <= bidx + 2'd1;
      end
    end
  end

  // NOTE: the array has no reset; stale contents are hidden by the
  // words_loaded compare on the fetch path, so clearing it is unnecessary.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[widx[AW-1:0]] <= wdata;
    end
  end

  assign words_loaded = widx;

  // Fetch path: zero latency, word-aligned, masked beyond the loaded region.
  logic [AW-1:0] wa;
  logic          addr_hi_zero;
  logic          unused_addr_lsbs;

  assign wa               = imem_addr[AW+1:2];
  assign addr_hi_zero     = (imem_addr[XLEN-1:AW+2] == '0);
  assign unused_addr_lsbs = ^imem_addr[1:0];

  always_comb begin
    imem_data = NOP;
    if (addr_hi_zero && ({1'b0, wa} < widx)) begin
      imem_data = mem[wa];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // DEPTH=256 instance
  logic [31:0] imem_addr, imem_data;
  logic        ld_valid, ld_ready, ld_last;
  logic [7:0]  ld_data;
  logic        core_reset, load_done, load_err;
  logic [8:0]  words_loaded;

  // DEPTH=4 instance for overflow / full-array cases
  logic [31:0] imem_addr_4, imem_data_4;
  logic        ld_valid_4, ld_ready_4, ld_last_4;
  logic [7:0]  ld_data_4;
  logic        core_reset_4, load_done_4, load_err_4;
  logic [2:0]  words_loaded_4;

  imem_loader #(.XLEN(32), .DEPTH(256)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .core_reset(core_reset), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  imem_loader #(.XLEN(32), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr_4), .imem_data(imem_data_4),
    .ld_valid(ld_valid_4), .ld_ready(ld_ready_4), .ld_data(ld_data_4), .ld_last(ld_last_4),
    .core_reset(core_reset_4), .load_done(load_done_4), .load_err(load_err_4),
    .words_loaded(words_loaded_4)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  stim  [$];
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference packing: little-endian bytes, missing high bytes are zero.
  function automatic logic [31:0] model_word(input int w);
    logic [31:0] word;
    word = '0;
    for (int b = 0; b < 4; b++) begin
      if (4*w + b < stim.size()) word[8*b +: 8] = stim[4*w + b];
    end
    return word;
  endfunction

  task automatic idle();
    @(negedge clk);
    ld_valid   = 1'b0; ld_last   = 1'b0;
    ld_valid_4 = 1'b0; ld_last_4 = 1'b0;
  endtask

  task automatic drive(input bit sel4, input logic [7:0] d, input logic last);
    @(negedge clk);
    if (sel4) begin
      ld_valid_4 = 1'b1; ld_data_4 = d; ld_last_4 = last;
      ld_valid   = 1'b0; ld_last   = 1'b0;
    end else begin
      ld_valid   = 1'b1; ld_data   = d; ld_last   = last;
      ld_valid_4 = 1'b0; ld_last_4 = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ld_valid = 1'b0; ld_last = 1'b0; ld_valid_4 = 1'b0; ld_last_4 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fetch(input bit sel4, input logic [31:0] a, output logic [31:0] d);
    if (sel4) imem_addr_4 = a; else imem_addr = a;
    #1;
    d = sel4 ? imem_data_4 : imem_data;
  endtask

  // Streams stim[]; gapped inserts an idle cycle (with junk data and ld_last
  // high) after every byte. Expected words go onto the scoreboard.
  task automatic run_stream(input bit sel4, input bit gapped, input bit with_last, input int depth);
    int n;
    n = stim.size();
    for (int i = 0; i < n; i++) begin
      drive(sel4, stim[i], with_last && (i == n - 1));
      if (with_last && i == n - 1)
        check("core_reset_before_last", 32'(sel4 ? core_reset_4 : core_reset), 32'd1);
      if (gapped && i != n - 1) begin
        @(negedge clk);
        if (sel4) begin ld_valid_4 = 1'b0; ld_data_4 = 8'hEE; ld_last_4 = 1'b1; end
        else      begin ld_valid   = 1'b0; ld_data   = 8'hEE; ld_last   = 1'b1; end
      end
    end
    idle();
    if (with_last)
      check("core_reset_after_last", 32'(sel4 ? core_reset_4 : core_reset), 32'd0);
    for (int w = 0; w < (n + 3) / 4 && w < depth; w++) exp_q.push_back(model_word(w));
  endtask

  task automatic check_words(input bit sel4, input int n, input string tag);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      fetch(sel4, 32'(4*i), d);
      check(tag, d, exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    imem_addr = '0; imem_addr_4 = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    ld_valid_4 = 1'b0; ld_data_4 = '0; ld_last_4 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_ld_ready",     32'(ld_ready),     32'd1);
    check("rst_core_reset",   32'(core_reset),   32'd1);
    check("rst_load_done",    32'(load_done),    32'd0);
    check("rst_load_err",     32'(load_err),     32'd0);
    check("rst_words_loaded", 32'(words_loaded), 32'd0);
    fetch(0, 32'h0, rd);  check("rst_fetch0", rd, NOP);
    check("rst_ld_ready_4",   32'(ld_ready_4),   32'd1);

    // Two full words
    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_stream(0, 0, 1, 256);
    check("s1_words_loaded", 32'(words_loaded), 32'd2);
    check("s1_load_done",    32'(load_done),    32'd1);
    check("s1_ld_ready",     32'(ld_ready),     32'd0);
    check_words(0, 2, "s1_word");
    fetch(0, 32'h8, rd);  check("s1_fetch8_nop", rd, NOP);

    // RUN-state fetch edge cases and ignored load port
    fetch(0, 32'hFFFF_FFF0, rd); check("run_fetch_high_nop", rd, NOP);
    fetch(0, 32'h0000_0400, rd); check("run_fetch_alias_nop", rd, NOP);
    fetch(0, 32'h0000_0002, rd); check("run_fetch_unaligned", rd, 32'h0000_0013);
    for (int i = 0; i < 3; i++) drive(0, 8'hFF, 1'b1);
    check("run_ld_ready", 32'(ld_ready), 32'd0);
    idle();
    check("run_words_unchanged", 32'(words_loaded), 32'd2);
    fetch(0, 32'h0, rd); check("run_word0_unchanged", rd, 32'h0000_0013);
    check("run_load_done_holds", 32'(load_done), 32'd1);

    // Reset from RUN
    do_reset();
    check("rerst_core_reset", 32'(core_reset), 32'd1);
    fetch(0, 32'h4, rd); check("rerst_fetch_nop", rd, NOP);

    // Partial final word
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    run_stream(0, 0, 1, 256);
    check("s2_words_loaded", 32'(words_loaded), 32'd2);
    check_words(0, 2, "s2_word");

    // Reset mid-load discards the partial word
    do_reset();
    stim = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    run_stream(0, 0, 0, 0);
    check("s4_mid_words", 32'(words_loaded), 32'd1);
    do_reset();
    check("s4_after_rst_words", 32'(words_loaded), 32'd0);
    stim = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_stream(0, 0, 1, 256);
    check("s4_words_loaded", 32'(words_loaded), 32'd1);
    check_words(0, 1, "s4_word");
    fetch(0, 32'h4, rd); check("s4_stale_masked", rd, NOP);

    // Gapped stream reproduces the first load
    do_reset();
    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_stream(0, 1, 1, 256);
    check("gap_words_loaded", 32'(words_loaded), 32'd2);
    check_words(0, 2, "gap_word");
    fetch(0, 32'h8, rd); check("gap_fetch8_nop", rd, NOP);

    // DEPTH=4 overflow: 20 bytes, ld_last on the 20th
    do_reset();
    stim.delete();
    for (int i = 1; i <= 20; i++) stim.push_back(8'(i));
    for (int i = 0; i < 16; i++) drive(1, stim[i], 1'b0);
    idle();
    check("ov_words_at16", 32'(words_loaded_4), 32'd4);
    check("ov_err_at16",   32'(load_err_4),     32'd0);
    drive(1, stim[16], 1'b0);
    idle();
    check("ov_err_at17",        32'(load_err_4),     32'd1);
    check("ov_words_at17",      32'(words_loaded_4), 32'd4);
    check("ov_core_reset_at17", 32'(core_reset_4),   32'd1);
    drive(1, stim[17], 1'b0);
    drive(1, stim[18], 1'b0);
    drive(1, stim[19], 1'b1);
    idle();
    check("ov_load_done",  32'(load_done_4),  32'd1);
    check("ov_core_reset", 32'(core_reset_4), 32'd0);
    check("ov_err_sticky", 32'(load_err_4),   32'd1);
    for (int w = 0; w < 4; w++) exp_q.push_back(model_word(w));
    check_words(1, 4, "ov_word");
    fetch(1, 32'h10, rd); check("ov_fetch_beyond_nop", rd, NOP);

    // DEPTH=4 exact fill: ld_last on byte 16
    do_reset();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(8'(8'hA0 + i));
    run_stream(1, 0, 1, 4);
    check("full_words", 32'(words_loaded_4), 32'd4);
    check("full_err",   32'(load_err_4),     32'd0);
    check("full_done",  32'(load_done_4),    32'd1);
    check_words(1, 4, "full_word");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory responder for the single-cycle RV32I core. It answers the core's `imem_addr` fetches with 32-bit words combinationally, and fills its word array from an external byte-stream load port. While loading, it holds the core in reset. Once the stream's last byte is accepted, it releases the core, which begins fetching at address 0.

## Interface
Parameters:
- `XLEN`, 32, width of `imem_addr` (matches core `XLEN`).
- `DEPTH`, 256, memory size in 32-bit words; power of two, ≥ 2. `AW = $clog2(DEPTH)`.
- `NOP`, 32'h0000_0013, word returned for unloaded or out-of-range fetches (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_addr` in XLEN: byte address from core; bits [1:0] ignored.
- `imem_data` out 32: fetched instruction word; combinational from `imem_addr`.
- `ld_valid` in 1: load byte present.
- `ld_ready` out 1: block accepts a byte this cycle.
- `ld_data` in 8: load byte; little-endian within each word.
- `ld_last` in 1: qualifies the final byte of the stream; sampled only on accept.
- `core_reset` out 1: drives the core's `reset`; high until the load completes.
- `load_done` out 1: high in RUN.
- `load_err` out 1: sticky overflow flag.
- `words_loaded` out AW+1: number of words written (0..DEPTH).

## Operation
- A byte is accepted when `ld_valid && ld_ready` at the clock edge.
- State LOAD:
  - Entered on reset.
  - `ld_ready=1`, `core_reset=1`, `load_done=0`.
  - Holds a 2-bit byte index `bidx`, a 24-bit assembler `asm` for bytes 0..2, and a word index `widx` = `words_loaded`.
- Accept with `bidx<3` and `ld_last=0`:
  - `asm[8*bidx +: 8] <= ld_data`.
  - `bidx++`.
- Accept with `bidx==3`, or with `ld_last=1`:
  - Writes `{ld_data at lane bidx, asm lanes below bidx}` to `mem[widx]`, with lanes above `bidx` zero.
  - Then `widx++`, `bidx<=0`, `asm<=0`.
- Accept with `ld_last=1`: after the write above, transition to RUN.
- Overflow (accept while `widx==DEPTH`):
  - Byte dropped; no write.
  - `load_err<=1` (sticky until reset).
  - `widx` and `bidx` unchanged.
  - `ld_last` still transitions to RUN.
- State RUN:
  - `ld_ready=0`, `core_reset=0`, `load_done=1`.
  - Load port ignored.
  - Stays in RUN until `reset`.
- Fetch path:
  - `wa = imem_addr[AW+1:2]`.
  - `imem_data = mem[wa]` if `imem_addr[XLEN-1:AW+2]==0` and `wa < words_loaded`; otherwise `NOP`.
  - Valid in both states. During LOAD the core is in reset, so fetches are don't-care.
- The memory array is not cleared by reset. Unloaded words are masked by the `words_loaded` compare.
- The memory has no write path from the core.

## Timing
- Reset values:
  - State LOAD; `bidx=0`, `asm=0`, `words_loaded=0`.
  - `ld_ready=1`, `core_reset=1`, `load_done=0`, `load_err=0`.
  - `imem_data=NOP` for every address.
- `ld_ready` is a registered state decode. It does not depend combinationally on `ld_valid`.
- Throughput: one byte per cycle with no bubbles.
- Load-completion timing: the word containing the `ld_last` byte is written at edge E, and the state becomes RUN at the same edge.
  - `core_reset` falls after E.
  - The core's first fetch of address 0 then occurs in that cycle, and the written word is visible there.
- Fetch latency: zero cycles; `imem_data` is combinational from `imem_addr` and the array.
- A write at edge E is visible to a fetch of the same word from the cycle after E.
- `reset` asserted mid-load, at any `bidx` or `widx`:
  - All registers return to their reset values at the next edge.
  - Any partial word in `asm` is discarded.
  - Previously written array contents remain but are masked, since `words_loaded=0`.
- `reset` in RUN: returns to LOAD and re-asserts `core_reset` at the next edge.
- `ld_last` on the 4×DEPTH-th byte: the word is written, `words_loaded=DEPTH`, the state goes to RUN, and `load_err=0`.
- `ld_valid=0` cycles: no state change.

## Test plan
- Load bytes 13 00 00 00 93 00 10 00 with `ld_last` on the 8th byte:
  - Required: `mem[0]`=0x00000013, `mem[1]`=0x00100093, `words_loaded`=2.
  - Required: `core_reset` falls the cycle after the last accept.
  - Required: fetch 0x4 gives 0x00100093; fetch 0x8 gives NOP.
- Load 6 bytes AA BB CC DD 11 22 with `ld_last` on 22:
  - Required: `mem[1]`=0x00002211, `words_loaded`=2.
- `DEPTH=4`: stream 20 bytes, `ld_last` on the 20th:
  - Required: `words_loaded`=4 and `load_err`=1 after the 17th byte.
  - Required: `mem[3]` equals the 13th–16th bytes; RUN is entered.
- Load 5 bytes, then assert `reset` for 1 cycle, then load 4 bytes 01 02 03 04 with `ld_last`:
  - Required: `mem[0]`=0x04030201, `words_loaded`=1, and the stale partial word is not seen.
- In RUN:
  - Fetch 0xFFFF_FFF0 → NOP.
  - Fetch 0x2 → `mem[0]`.
  - Drive `ld_valid=1` → `ld_ready=0` and contents unchanged.
- Gapped stream: `ld_valid` toggles every other cycle across 8 bytes → identical result to the first scenario; no byte lost or duplicated.
